dpbram_fifo_ctrl: RTL
=====================

Name: dpbram_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences the team's simple dual-port BRAM: write port A for pushes, read port B (1-cycle registered read) for pops. It provides valid/ready handshakes on both sides and hides the BRAM read latency with a show-ahead output stage, sustaining 1 push + 1 pop per cycle. Used as the standard buffering element between streaming producers and consumers in one clock domain.

Parameters:
DATA_WIDTH, 32, payload width.
ADDR_WIDTH, 10, BRAM address width; memory depth DEPTH = 2**ADDR_WIDTH.
AFULL_LVL, DEPTH-4, o_almost_full asserts when o_level >= AFULL_LVL.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_flush  in  1  synchronous clear of all contents.
i_wr_valid  in  1  push request.
i_wr_data  in  DATA_WIDTH  push payload.
o_wr_ready  out  1  high when memory not full.
i_rd_ready  in  1  consumer accepts o_rd_data.
o_rd_valid  out  1  o_rd_data holds the head entry.
o_rd_data  out  DATA_WIDTH  head entry (BRAM port-B output, no extra register).
o_level  out  ADDR_WIDTH+1  entries held: memory count + o_rd_valid.
o_almost_full  out  1  o_level >= AFULL_LVL.
o_overflow  out  1  one-cycle pulse: push attempted while o_wr_ready low.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, mem_cnt=0, o_rd_valid=0, o_level=0, o_overflow=0, o_almost_full=0 (if AFULL_LVL>0); o_wr_ready=1. o_rd_data undefined until first pop issue.
- Pointers ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally; mem_cnt ADDR_WIDTH+1 bits, range 0..DEPTH.
- o_wr_ready = (mem_cnt != DEPTH); combinational from registered state only.
- Push accepted when i_wr_valid & o_wr_ready & !i_flush: drive enA=weA=1, addrA=wr_ptr, dinA=i_wr_data; wr_ptr++.
- Issue (BRAM read) when mem_cnt != 0 & (!o_rd_valid | i_rd_ready) & !i_flush: enB=1, addrB=rd_ptr; rd_ptr++; next cycle o_rd_valid=1 with data.
- Pop completes when o_rd_valid & i_rd_ready; if no issue same cycle, o_rd_valid<=0. enB low otherwise, so port-B output holds head data while stalled.
- mem_cnt next = mem_cnt + push - issue; push and issue in same cycle leave it unchanged.
- Latency: push at cycle N into empty FIFO -> mem_cnt=1 at N+1 -> issue N+1 -> o_rd_valid at N+2.
- Issue reads only committed entries, so no same-address read/write collision occurs.
- Capacity: DEPTH in memory plus 1 in output stage; o_level max DEPTH+1.
- i_flush: next cycle pointers, mem_cnt, o_rd_valid = 0; flush wins over same-cycle push/pop (both dropped, no overflow pulse).
- o_overflow = registered (i_wr_valid & !o_wr_ready & !i_flush).
- Pop with o_rd_valid=0 is ignored (no underflow state).
- Reset mid-operation: all state cleared immediately; BRAM contents not cleared and irrelevant.

Decomposition:
- Shared package: none required; width derivations (DEPTH, level width) as localparams.
- One sub-module: instance of the existing wbDPBRAM (DATA_WIDTH, ADDR_WIDTH passed through); controller is pointer/count/handshake logic only.

Test Plan:
- DATA_WIDTH=8, ADDR_WIDTH=2. After reset: o_wr_ready=1, o_rd_valid=0, o_level=0; push 0xA5 at cycle 0 -> o_rd_valid=1 with 0xA5 at cycle 2, o_level=1.
- i_rd_ready=0, push 0x01..0x05 -> o_wr_ready=0 after 5th accept, o_level=5; 6th push 0x06 -> o_overflow pulses 1 cycle, then pops return 01..05 in order.
- Continuous push+pop with i_rd_ready=1 for 20 cycles, data 0x00..0x13 -> output 0x00..0x13 back-to-back, no bubbles after first, pointers wrap 4 times, o_level steady at 2.
- Stall: o_rd_valid=1 with 0x11, i_rd_ready low 3 cycles while pushes 0x22,0x33 -> o_rd_data stays 0x11; then pops give 0x11,0x22,0x33.
- Flush with o_level=3 and simultaneous push 0x77 -> next cycle o_level=0, o_rd_valid=0, 0x77 never appears.
- Assert i_rst_n low mid-stream (asynchronously, between edges) -> outputs go to reset values immediately; after release, push 0x5A -> read 0x5A at +2 cycles.

Source files
------------

// File: rtl/wbDPBRAM.sv
// Simple dual-port block RAM: port A write-only, port B read-only with a registered output.
// Port B output only updates when enb is high, so it holds its last value while idle.
module wbDPBRAM #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_ff @(posedge i_clk) begin
    if (enb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/dpbram_fifo_ctrl.sv
// Single-clock FIFO around wbDPBRAM with a show-ahead output stage that hides
// the one-cycle port-B read latency; sustains one push and one pop per cycle.
module dpbram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_rd_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_almost_full,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0]      DEPTH_C = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      AFULL_C = LVL_W'(AFULL_LVL);
  localparam logic [LVL_W-1:0]      CNT_ONE = LVL_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]      mem_cnt;
  logic                  rd_valid;
  logic                  overflow;
  logic                  push;
  logic                  issue;

  assign o_wr_ready = (mem_cnt != DEPTH_C);

  // Only committed entries (mem_cnt) are read, so port B never races port A.
  assign push  = i_wr_valid && o_wr_ready && !i_flush;
  assign issue = (mem_cnt != '0) && (!rd_valid || i_rd_ready) && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= i_wr_valid && !o_wr_ready && !i_flush;
      if (i_flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        mem_cnt  <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PTR_ONE;
        if (issue) rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !issue)      mem_cnt <= mem_cnt + CNT_ONE;
        else if (issue && !push) mem_cnt <= mem_cnt - CNT_ONE;
        if (issue)                       rd_valid <= 1'b1;
        else if (rd_valid && i_rd_ready) rd_valid <= 1'b0;
      end
    end
  end

  assign o_rd_valid    = rd_valid;
  assign o_level       = mem_cnt + {{ADDR_WIDTH{1'b0}}, rd_valid};
  assign o_almost_full = (o_level >= AFULL_C);
  assign o_overflow    = overflow;

  wbDPBRAM #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .i_clk (i_clk),
    .ena   (push),
    .wea   (push),
    .addra (wr_ptr),
    .dina  (i_wr_data),
    .enb   (issue),
    .addrb (rd_ptr),
    .doutb (o_rd_data)
  );

endmodule
